// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit and its controller:
// operation codes, FSM state encoding and a small op classifier.
package md_defs;

    // MD operation codes as issued by the decode stage
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Unit FSM: IDLE accepts requests, RUN counts down a multi-cycle op
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    // True for the two division flavours
    function automatic logic md_is_div(input md_op_e o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Multi-cycle ops capture their operands on acceptance and write HI/LO when
// a countdown expires; MTHI/MTLO write directly in a single cycle.
module md_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    md_op_e          op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    // Result datapath signals
    logic [63:0] mul_a, mul_b, prod;
    logic        mul_sgn, div_sgn, a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    // Result from captured operands; one 64-bit multiplier serves both
    // signednesses via extension, division works on magnitudes so the
    // 0x80000000 / -1 case falls out as quotient 0x80000000, remainder 0.
    always_comb begin
        mul_sgn = (op_q == MD_MULT);
        mul_a   = {{32{mul_sgn & a_q[31]}}, a_q};
        mul_b   = {{32{mul_sgn & b_q[31]}}, b_q};
        prod    = mul_a * mul_b;

        div_sgn = (op_q == MD_DIV);
        a_neg   = div_sgn & a_q[31];
        b_neg   = div_sgn & b_q[31];
        a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
        b_zero  = (b_q == 32'd0);
        // Keep the divider defined on a zero divisor; the result is discarded
        b_safe  = b_zero ? 32'd1 : b_mag;
        q_mag   = a_mag / b_safe;
        r_mag   = a_mag % b_safe;
        quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

        if (md_is_div(op_q)) begin
            res_hi = rem;
            res_lo = quot;
            res_wr = ~b_zero;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
        end
    end

    // Next state: request acceptance in IDLE, countdown and writeback in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            op_d    = md_op_e'(op);
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = CntW'(MULT_CYCLES - 1);
                            state_d = StRun;
                        end
                        MD_DIV, MD_DIVU: begin
                            op_d    = md_op_e'(op);
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = CntW'(DIV_CYCLES - 1);
                            state_d = StRun;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // start is deliberately ignored while running
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter, captured operands and HI/LO; reset wins over everything
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == StRun);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table-driven vectors, random unsigned and
// signed operations checked against a scoreboard, plus hand-written sequences
// for start-while-busy and reset-during-run.
module tb_md_unit;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        clr_n, start;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one request for a cycle and push its expected outcome
    task automatic issue(input bit rel, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi,
                         input logic [31:0] elo, input int ecyc);
        exp_t e;
        @(negedge clk);
        if (rel) clr_n = 1'b1;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        e.hi  = ehi;
        e.lo  = elo;
        e.cyc = ecyc;
        sb.push_back(e);
        m_hi  = ehi;
        m_lo  = elo;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble operands so any use of live inputs shows up
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count busy cycles until completion (bounded) and compare with the scoreboard
    task automatic wait_done(input string name);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no expectation queued expected one", name);
        end else begin
            e = sb.pop_front();
            check({name, " busy_cycles"}, 64'(n), 64'(e.cyc));
            check({name, " hi_lo"}, {hi, lo}, {e.hi, e.lo});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt[12];
        logic [31:0] av, bv;
        logic [63:0] p;
        longint      ps;

        vt[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vt[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vt[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vt[4]  = '{MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vt[5]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[6]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vt[7]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vt[8]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vt[9]  = '{MD_MTHI,  32'h0000A5A5, 32'd0,        32'h0000A5A5, 32'h00000001, 0};
        vt[10] = '{MD_MTLO,  32'h00005A5A, 32'd0,        32'h0000A5A5, 32'h00005A5A, 0};
        vt[11] = '{MD_DIV,   32'd7,        32'd0,        32'h0000A5A5, 32'h00005A5A, 10};

        clr_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);

        // Request presented on the very first edge with reset released
        issue(1'b1, MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        wait_done("first_after_reset");

        for (int i = 0; i < 12; i++) begin
            issue(1'b0, vt[i].op, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo, vt[i].ecyc);
            wait_done($sformatf("vec%0d", i));
        end

        // Undefined op codes leave everything untouched
        issue(1'b0, 3'd6, 32'h12345678, 32'd1, m_hi, m_lo, 0);
        wait_done("undef_op6");
        issue(1'b0, 3'd7, 32'h87654321, 32'd1, m_hi, m_lo, 0);
        wait_done("undef_op7");

        // Random operations against bench arithmetic
        for (int i = 0; i < 4; i++) begin
            av = $urandom;
            bv = $urandom;
            if (bv == 32'd0) bv = 32'd1;
            p = {32'd0, av} * {32'd0, bv};
            issue(1'b0, MD_MULTU, av, bv, p[63:32], p[31:0], 5);
            wait_done($sformatf("rnd_multu%0d", i));
            issue(1'b0, MD_DIVU, av, bv >> (i * 8), av % (bv >> (i * 8)) ,
                  av / (bv >> (i * 8)), 10);
            if ((bv >> (i * 8)) == 32'd0) begin
                // Zero divisor after shift: result must be unchanged instead
                sb[sb.size() - 1].hi = p[63:32];
                sb[sb.size() - 1].lo = p[31:0];
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            wait_done($sformatf("rnd_divu%0d", i));
            ps = longint'($signed(av)) * longint'($signed(bv));
            issue(1'b0, MD_MULT, av, bv, ps[63:32], ps[31:0], 5);
            wait_done($sformatf("rnd_mult%0d", i));
        end

        // DIVU by zero after preloading HI/LO
        issue(1'b0, MD_MTHI, 32'h11, 32'd0, 32'h11, m_lo, 0);
        wait_done("preload_hi");
        issue(1'b0, MD_MTLO, 32'h22, 32'd0, 32'h11, 32'h22, 0);
        wait_done("preload_lo");
        issue(1'b0, MD_DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 10);
        wait_done("divu_by_zero");

        // MTLO and DIV presented while a MULT is running are ignored
        issue(1'b0, MD_MULT, 32'd6, 32'd7, 32'd0, 32'h2A, 2);
        @(negedge clk);
        check("busy_run c1", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("busy_run c2", {63'd0, busy}, 64'd1);
        start = 1'b1;
        op    = MD_MTLO;
        a     = 32'h1234;
        @(negedge clk);
        check("busy_run c3", {63'd0, busy}, 64'd1);
        check("mtlo_ignored lo", {32'd0, lo}, 64'h22);
        op    = MD_DIV;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("mult_ignores_start");
        repeat (12) @(negedge clk);
        check("late busy", {63'd0, busy}, 64'd0);
        check("late hi_lo", {hi, lo}, {32'd0, 32'h2A});

        // Reset in the middle of a DIV aborts it without any write
        issue(1'b0, MD_MTHI, 32'h99, 32'd0, 32'h99, 32'h2A, 0);
        wait_done("preload_hi2");
        @(negedge clk);
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hi_lo", {hi, lo}, 64'd0);
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort no_write busy", {63'd0, busy}, 64'd0);
        check("abort no_write hi_lo", {hi, lo}, 64'd0);
        issue(1'b0, MD_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        wait_done("mult_after_abort");

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
